// File: rtl/pow_fact_seq.sv
// Zero / square / cube / factorial of an unsigned operand using one iterated multiplier.
// Latency: 1 edge (zero, 0!, 1!), 2 (square), 3 (cube), x edges for x!.
// Backpressure: start is ignored while busy; out/ovf hold until the next done or rst.
module pow_fact_seq #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IN_W-1:0]  in,
    input  logic [1:0]       s,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] out,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   acc, mult;
    logic [IN_W-1:0]    k;
    logic               fact;
    logic               ovf_run;

    logic [OUT_W-1:0]   acc_init, mult_init;
    logic [IN_W-1:0]    k_init;
    logic [2*OUT_W-1:0] prod;
    logic               prod_ovf;

    always_comb begin
        acc_init  = '0;
        mult_init = '0;
        k_init    = '0;
        case (s)
            2'b01: begin
                acc_init  = OUT_W'(in);
                mult_init = OUT_W'(in);
                k_init    = IN_W'(1);
            end
            2'b10: begin
                acc_init  = OUT_W'(in);
                mult_init = OUT_W'(in);
                k_init    = IN_W'(2);
            end
            2'b11: begin
                acc_init  = OUT_W'(1);
                mult_init = OUT_W'(2);
                k_init    = (in == '0) ? '0 : in - IN_W'(1);
            end
            default: ;
        endcase
    end

    // Full-width product so the overflow check sees every discarded bit.
    assign prod     = {{OUT_W{1'b0}}, acc} * {{OUT_W{1'b0}}, mult};
    assign prod_ovf = |prod[2*OUT_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE) && !rst;
        case (state)
            IDLE:    if (start) state_nxt = (k_init == '0) ? DONE : CALC;
            CALC:    if (k == IN_W'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out/ovf are loaded on the edge entering DONE so they are valid alongside done.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mult    <= '0;
            k       <= '0;
            fact    <= 1'b0;
            ovf_run <= 1'b0;
            out     <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc     <= acc_init;
                    mult    <= mult_init;
                    k       <= k_init;
                    fact    <= (s == 2'b11);
                    ovf_run <= 1'b0;
                    if (k_init == '0) begin
                        out <= acc_init;
                        ovf <= 1'b0;
                    end
                end
                CALC: begin
                    acc     <= prod[OUT_W-1:0];
                    k       <= k - IN_W'(1);
                    ovf_run <= ovf_run | prod_ovf;
                    if (fact) mult <= mult + OUT_W'(1);
                    if (k == IN_W'(1)) begin
                        out <= prod[OUT_W-1:0];
                        ovf <= ovf_run | prod_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pow_fact_seq.sv
// Directed bench for pow_fact_seq: a default-size instance and a 6-in/64-out instance.
// Runs to a single summary line.
module tb_pow_fact_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_start, a_busy, a_done, a_ovf;
    logic [3:0]  a_in;
    logic [1:0]  a_s;
    logic [15:0] a_out;
    logic        b_start, b_busy, b_done, b_ovf;
    logic [5:0]  b_in;
    logic [1:0]  b_s;
    logic [63:0] b_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pow_fact_seq #(.IN_W(4), .OUT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in(a_in), .s(a_s),
        .busy(a_busy), .done(a_done), .out(a_out), .ovf(a_ovf)
    );

    pow_fact_seq #(.IN_W(6), .OUT_W(64)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in(b_in), .s(b_s),
        .busy(b_busy), .done(b_done), .out(b_out), .ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one op, scramble in/s after acceptance, count edges (accepting edge included) to done.
    task automatic run_op(input bit sel, input logic [1:0] mode, input logic [5:0] x,
                          input logic [63:0] exp_out, input logic exp_ovf,
                          input int exp_edges, input string tag);
        int edges;
        bit seen;
        @(negedge clk);
        if (sel) begin b_start = 1'b1; b_s = mode; b_in = x; end
        else     begin a_start = 1'b1; a_s = mode; a_in = x[3:0]; end
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
        a_in = ~a_in;  a_s = ~a_s;
        b_in = ~b_in;  b_s = ~b_s;
        check({tag, ".busy"}, 64'(sel ? b_busy : a_busy), 64'd1);
        edges = 1;
        seen  = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (sel ? b_done : a_done) seen = 1'b1;
            else begin
                @(posedge clk);
                edges++;
            end
        end
        check({tag, ".done"},  64'(seen), 64'd1);
        check({tag, ".edges"}, 64'(edges), 64'(exp_edges));
        check({tag, ".out"},   sel ? b_out : 64'(a_out), exp_out);
        check({tag, ".ovf"},   64'(sel ? b_ovf : a_ovf), 64'(exp_ovf));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        rst = 1'b1;
        a_start = 1'b0; a_in = '0; a_s = '0;
        b_start = 1'b0; b_in = '0; b_s = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst.out",  64'(a_out),  64'd0);
        check("rst.ovf",  64'(a_ovf),  64'd0);
        check("rst.busy", 64'(a_busy), 64'd0);
        check("rst.done", 64'(a_done), 64'd0);
        check("rst.b_out", b_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(0, 2'b01, 6'd13, 64'd169,   1'b0, 2, "sq13");
        run_op(0, 2'b10, 6'd15, 64'd3375,  1'b0, 3, "cube15");
        run_op(0, 2'b00, 6'd9,  64'd0,     1'b0, 1, "zero9");
        run_op(0, 2'b11, 6'd0,  64'd1,     1'b0, 1, "fact0");
        run_op(0, 2'b11, 6'd1,  64'd1,     1'b0, 1, "fact1");
        run_op(0, 2'b11, 6'd5,  64'd120,   1'b0, 5, "fact5");
        run_op(0, 2'b11, 6'd8,  64'd40320, 1'b0, 8, "fact8");
        run_op(0, 2'b11, 6'd9,  64'd35200, 1'b1, 9, "fact9");
        run_op(0, 2'b01, 6'd3,  64'd9,     1'b0, 2, "sq3");

        // Abort a factorial-7 run three edges in; no done may follow.
        @(negedge clk);
        a_start = 1'b1; a_s = 2'b11; a_in = 4'd7;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("abort.done_in_rst", 64'(a_done), 64'd0);
        @(posedge clk);
        #1;
        check("abort.busy", 64'(a_busy), 64'd0);
        check("abort.done", 64'(a_done), 64'd0);
        check("abort.out",  64'(a_out),  64'd0);
        check("abort.ovf",  64'(a_ovf),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_done) dones++;
        end
        check("abort.no_done", 64'(dones), 64'd0);

        // Hammer start while busy; only the first square of 2 may run.
        @(negedge clk);
        a_start = 1'b1; a_s = 2'b01; a_in = 4'd2;
        @(posedge clk);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_done) dones++;
            if (a_busy) begin
                a_start = 1'b1;
                a_in    = 4'(i + 5);
            end else begin
                a_start = 1'b0;
            end
        end
        a_start = 1'b0;
        check("abuse.dones", 64'(dones), 64'd1);
        check("abuse.out",   64'(a_out), 64'd4);

        // Second op starts in the IDLE cycle right after the first done.
        run_op(0, 2'b01, 6'd7, 64'd49, 1'b0, 2, "b2b1");
        run_op(0, 2'b10, 6'd3, 64'd27, 1'b0, 3, "b2b2");

        run_op(1, 2'b11, 6'd20, 64'd2432902008176640000,  1'b0, 20, "f20");
        run_op(1, 2'b11, 6'd21, 64'd14197454024290336768, 1'b1, 21, "f21");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
